// File: rtl/uart_sim_pkg.sv
// Shared types and baud-rate helpers for the simulation-side UART receive monitor.
package uart_sim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Clock cycles per bit (half = 0) or per half bit (half = 1), integer division.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input bit          half);
    int unsigned cpb;
    cpb = clk_hz / baud;
    return half ? (cpb / 2) : cpb;
  endfunction

  function automatic int unsigned baud_cnt_width(input int unsigned cpb);
    return $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_sim_fifo.sv
// Synchronous show-ahead byte FIFO; full/empty told apart by an extra pointer MSB.
module uart_sim_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic                     empty,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wr_ptr;
  logic [AddrW:0]   rd_ptr;
  logic [Width-1:0] mem [Depth];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                   (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = empty ? '0 : mem[rd_ptr[AddrW-1:0]];
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[AddrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_sim_rx_monitor.sv
// 8N1 UART receive monitor: synchroniser, mid-bit sampling FSM, byte FIFO, error flags, byte count.
module uart_sim_rx_monitor
  import uart_sim_pkg::*;
#(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rx_i,
  output logic                         byte_valid_o,
  output logic [7:0]                   byte_o,
  input  logic                         byte_ready_i,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o,
  output logic [15:0]                  bytes_rcvd_o
);

  localparam int unsigned ClksPerBit = clks_per_bit(ClockFrequency, BaudRate, 1'b0);
  localparam int unsigned HalfBit    = clks_per_bit(ClockFrequency, BaudRate, 1'b1);
  localparam int unsigned CntW       = baud_cnt_width(ClksPerBit);

  if (ClksPerBit < 4) begin : g_bad_baud
    $error("uart_sim_rx_monitor: ClksPerBit must be at least 4");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_sim_rx_monitor: FifoDepth must be a power of two >= 2");
  end

  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  logic            fall;
  rx_state_e       state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            push_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  // The assembled byte stays in shift through IDLE, so the FIFO can write it one edge after the stop sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      push_q      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CntW'(HalfBit - 1)) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CntW'(ClksPerBit - 1)) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CntW'(ClksPerBit - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_sync) push_q      <= 1'b1;
            else         frame_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_valid_o = ~fifo_empty;
  assign pop          = byte_valid_o & byte_ready_i;

  uart_sim_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push_q),
    .push_data (shift),
    .full      (fifo_full),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (byte_o),
    .level     (fifo_level_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o   <= 1'b0;
      bytes_rcvd_o <= '0;
    end else if (push_q) begin
      if (fifo_full && !pop) overflow_o   <= 1'b1;
      else                   bytes_rcvd_o <= bytes_rcvd_o + 16'd1;
    end
  end

endmodule
